// File: rtl/bus_interface_unit.sv
// External memory port: captures a one-cycle access request, runs one read or write
// cycle with setup, wait states and a timeout, and returns read data as the input latch.
module bus_interface_unit #(
  parameter int DATA_W       = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [7:0]        i_adh_data,
  input  logic [7:0]        i_adl_data,
  input  logic [DATA_W-1:0] i_db_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata,
  output logic [15:0]       o_mem_addr,
  output logic              o_mem_rw,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SCNT_W = $clog2(SETUP_CYCLES + 2);
  localparam int TCNT_W = $clog2(TIMEOUT + 2);

  state_t            r_state;
  state_t            w_next;
  logic [SCNT_W-1:0] r_scnt;
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_we;
  logic [15:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_accept;
  logic              w_setup_last;
  logic              w_timeout;
  logic              w_active;
  logic              w_drive_wr;

  // Memory handshake: an access completes at the rising edge where o_mem_valid and
  // i_mem_ready are both high; i_mem_ready is ignored whenever o_mem_valid is low.
  assign w_accept     = (r_state == ST_IDLE) && i_req;
  assign w_setup_last = (int'(r_scnt) <= 1);
  assign w_timeout    = (TIMEOUT != 0) && (int'(r_tcnt) == TIMEOUT - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_req) w_next = (SETUP_CYCLES == 0) ? ST_ACCESS : ST_SETUP;
      ST_SETUP:  if (w_setup_last) w_next = ST_ACCESS;
      ST_ACCESS: if (i_mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_addr  <= {i_adh_data, i_adl_data};
        r_wdata <= i_db_data;
        r_scnt  <= SCNT_W'(SETUP_CYCLES);
      end else if (r_state == ST_SETUP) begin
        r_scnt <= r_scnt - SCNT_W'(1);
      end
      if (r_state != ST_ACCESS) begin
        r_tcnt <= '0;
      end else if (!i_mem_ready && !w_timeout) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
      if ((r_state == ST_ACCESS) && i_mem_ready && !r_we) begin
        r_rdata <= i_mem_rdata;
      end
      // READY has priority over a timeout landing in the same cycle.
      if ((r_state == ST_ACCESS) && (w_next == ST_DONE)) begin
        r_err <= !i_mem_ready;
      end
    end
  end

  assign w_active    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign w_drive_wr  = w_active && r_we;
  assign o_mem_rw    = !w_drive_wr;
  assign o_mem_wdata = w_drive_wr ? r_wdata : '0;
  assign o_mem_valid = (r_state == ST_ACCESS);
  assign o_mem_addr  = r_addr;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_state     = r_state;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Bench for bus_interface_unit: random accesses checked by a scoreboard against a
// transaction-level model, plus directed cases on a zero-setup, no-timeout instance.
module tb_bus_interface_unit;
  localparam int SETUP   = 1;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we_i = 1'b0;
  logic [7:0]  adh = '0, adl = '0, db = '0;
  logic        busy, done, err, mem_rw, mem_valid, mem_ready = 1'b0;
  logic [7:0]  rdata, mem_wdata, mem_rdata = '0;
  logic [15:0] mem_addr;
  logic [1:0]  state;

  logic        req0 = 1'b0, we0 = 1'b0, ready0 = 1'b0;
  logic [7:0]  adh0 = '0, adl0 = '0, db0 = '0, mrdata0 = '0;
  logic        busy0, done0, err0, rw0, valid0;
  logic [7:0]  rdata0, wdata0;
  logic [15:0] addr0;
  logic [1:0]  state0;

  typedef struct packed {
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  vcyc;
    logic [31:0] issue;
  } exp_t;
  exp_t exp_q[$];

  int         total = 0, bad = 0, cyc = 0;
  int         cur_waits = 0, rvcnt = 0, vcnt = 0;
  logic [7:0] cur_rdata = '0, m_rdata = '0;

  bus_interface_unit #(.DATA_W(8), .SETUP_CYCLES(SETUP), .TIMEOUT(TIMEOUT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we_i), .i_adh_data(adh),
    .i_adl_data(adl), .i_db_data(db), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_rw(mem_rw), .o_mem_wdata(mem_wdata),
    .o_mem_valid(mem_valid), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
    .o_state(state));

  bus_interface_unit #(.DATA_W(8), .SETUP_CYCLES(0), .TIMEOUT(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_we(we0), .i_adh_data(adh0),
    .i_adl_data(adl0), .i_db_data(db0), .o_busy(busy0), .o_done(done0), .o_err(err0),
    .o_rdata(rdata0), .o_mem_addr(addr0), .o_mem_rw(rw0), .o_mem_wdata(wdata0),
    .o_mem_valid(valid0), .i_mem_rdata(mrdata0), .i_mem_ready(ready0),
    .o_state(state0));

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: READY rises on access cycle number cur_waits; random noise otherwise.
  always @(negedge clk) begin
    if (mem_valid) begin
      mem_ready = (rvcnt == cur_waits);
      mem_rdata = cur_rdata;
      rvcnt++;
    end else begin
      rvcnt = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      vcnt = 0;
    end else begin
      if (mem_valid) begin
        vcnt++;
        if (exp_q.size() == 0) chk("valid_without_request", 1, 0);
        else begin
          chk("acc_busy", busy, 1);
          chk("acc_addr", mem_addr, exp_q[0].addr);
          chk("acc_rw", mem_rw, !exp_q[0].we);
          chk("acc_wdata", mem_wdata, exp_q[0].we ? exp_q[0].wdata : 8'h00);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_without_request", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_err", err, e.err);
          chk("done_rdata", rdata, e.rdata);
          chk("done_valid_cycles", vcnt, e.vcyc);
          chk("done_latency", cyc - int'(e.issue), SETUP + 1 + int'(e.vcyc));
          chk("done_addr", mem_addr, e.addr);
          chk("done_rw", mem_rw, 1);
          chk("done_wdata", mem_wdata, 0);
          chk("done_valid_low", mem_valid, 0);
        end
        vcnt = 0;
      end
    end
  end

  // Driver: issue one access, then hammer REQ with junk until the unit is idle again.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] wd,
                           input int waits, input logic [7:0] rd);
    exp_t e;
    int   n;
    logic terr;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("idle_wait_expired", 1, 0);
    terr = (waits >= TIMEOUT);
    if (!w && !terr) m_rdata = rd;
    e.err   = terr;
    e.rdata = m_rdata;
    e.addr  = a;
    e.we    = w;
    e.wdata = wd;
    e.vcyc  = terr ? 8'(TIMEOUT) : 8'(waits + 1);
    e.issue = 32'(cyc);
    exp_q.push_back(e);
    cur_waits = waits;
    cur_rdata = rd;
    req = 1'b1; we_i = w; adh = a[15:8]; adl = a[7:0]; db = wd;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin
      req = 1'($urandom_range(0, 1));
      we_i = 1'($urandom); adh = 8'($urandom); adl = 8'($urandom); db = 8'($urandom);
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    if (n >= 100) chk("done_wait_expired", 1, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_rw", mem_rw, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-setup, no-timeout instance: VALID the cycle after REQ, DONE after two.
    ready0 = 1'b1; mrdata0 = 8'h3C;
    req0 = 1'b1; we0 = 1'b0; adh0 = 8'h80; adl0 = 8'h01;
    @(negedge clk);
    req0 = 1'b0;
    chk("z_valid", valid0, 1);
    chk("z_rw", rw0, 1);
    chk("z_addr", addr0, 16'h8001);
    @(negedge clk);
    chk("z_done", done0, 1);
    chk("z_rdata", rdata0, 8'h3C);
    chk("z_err", err0, 0);
    chk("z_valid_off", valid0, 0);
    @(negedge clk);
    ready0 = 1'b0; mrdata0 = 8'hD1;
    req0 = 1'b1; we0 = 1'b1; adh0 = 8'h02; adl0 = 8'h03; db0 = 8'h77;
    @(negedge clk);
    req0 = 1'b0;
    chk("z_wr_rw", rw0, 0);
    chk("z_wr_wdata", wdata0, 8'h77);
    repeat (8) begin
      chk("z_no_timeout_valid", valid0, 1);
      @(negedge clk);
    end
    ready0 = 1'b1;
    @(negedge clk);
    chk("z_wr_done", done0, 1);
    chk("z_wr_err", err0, 0);
    chk("z_wr_rdata", rdata0, 8'h3C);
    chk("z_wr_rw_back", rw0, 1);
    ready0 = 1'b0;

    // Directed accesses on the main instance
    do_access(1'b0, 16'h1234, 8'h00, 0, 8'hA9);
    do_access(1'b1, 16'h01FF, 8'h5C, 3, 8'h00);
    do_access(1'b0, 16'hBEEF, 8'h00, 9, 8'h11);
    do_access(1'b0, 16'h0042, 8'h00, 1, 8'h66);
    do_access(1'b0, 16'h0043, 8'h00, TIMEOUT - 1, 8'h5A);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), 16'($urandom), 8'($urandom), $urandom_range(0, 5),
                8'($urandom));
    end

    // Reset in the middle of an access
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    begin
      exp_t e;
      e.err = 1'b0; e.rdata = 8'h00; e.addr = 16'h4242; e.we = 1'b0;
      e.wdata = 8'h00; e.vcyc = 8'd0; e.issue = 32'(cyc);
      exp_q.push_back(e);
    end
    cur_waits = 100; cur_rdata = 8'hEE;
    req = 1'b1; we_i = 1'b0; adh = 8'h42; adl = 8'h42;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!mem_valid && n < 10) begin @(negedge clk); n++; end
    chk("mid_valid_reached", mem_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    exp_q.delete();
    m_rdata = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, 16'hC0DE, 8'h00, 2, 8'h99);
    do_access(1'b1, 16'h0100, 8'hAB, 0, 8'h00);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
